pwm_stage: RTL and testbench

PWM_STAGE -- requirements
Module: pwm_stage

---
 rtl/pwm_stage_pkg.sv | 14 +
 rtl/pwm_duty_shadow.sv | 45 ++++
 rtl/pwm_stage.sv | 73 +++++++
 tb/tb_pwm_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_stage_pkg.sv
// Shared types and constants for the PWM stage: FSM state encoding and widths.
package pwm_stage_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_COUNT = 4'hF;
  localparam int PER_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_duty_shadow.sv
// Duty handshake plus shadow register: decides when an accepted duty value
// reaches duty_active, either directly or deferred to the next period boundary.
module pwm_duty_shadow
  import pwm_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  pwm_state_e       state,
  input  logic             enable,
  input  logic             boundary,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             transfer,
  output logic [CNT_W-1:0] duty_active
);

  logic [CNT_W-1:0] shadow;

  // valid/ready: a value is accepted on a rising clk edge where duty_valid
  // and duty_ready are both high; ready drops only while a value is pending.
  assign duty_ready = (state != PEND);
  assign transfer   = duty_valid && duty_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      duty_active <= '0;
      shadow      <= '0;
    end else begin
      case (state)
        IDLE: if (transfer) duty_active <= duty_in;
        RUN: begin
          // A transfer that coincides with a boundary or a stop needs no deferral.
          if (transfer) begin
            if (boundary || !enable) duty_active <= duty_in;
            else                     shadow      <= duty_in;
          end
        end
        PEND: if (boundary || !enable) duty_active <= shadow;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pwm_stage.sv
// PWM stage: comparator, IDLE/RUN/PEND FSM and period tracking against an
// external count. Define PWM_PERIOD_CNT_EN to add the saturating periods counter.
module pwm_stage
  import pwm_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count,
  input  logic             enable,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic [CNT_W-1:0] duty_active,
  output logic             pwm_out,
  output logic             period_done,
`ifdef PWM_PERIOD_CNT_EN
  output logic [PER_W-1:0] periods,
`endif
  output pwm_state_e       state_dbg
);

  pwm_state_e state;
  logic       boundary;
  logic       transfer;

  assign state_dbg = state;
  // Only count==MAX marks a boundary; upstream reloads may shorten the period.
  assign boundary  = (state != IDLE) && (count == MAX_COUNT);

  pwm_duty_shadow u_duty (
    .clk         (clk),
    .rst         (rst),
    .state       (state),
    .enable      (enable),
    .boundary    (boundary),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .transfer    (transfer),
    .duty_active (duty_active)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm_out     <= (state != IDLE) && (count < duty_active);
      period_done <= boundary;
      case (state)
        IDLE: if (enable) state <= RUN;
        RUN: begin
          if (!enable)                     state <= IDLE;
          else if (transfer && !boundary)  state <= PEND;
        end
        PEND: begin
          if (!enable)       state <= IDLE;
          else if (boundary) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                                periods <= '0;
    else if (period_done && (periods != '1)) periods <= periods + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pwm_stage.sv
// Bench for pwm_stage: a reference model pushes expected outputs per cycle,
// popped and compared after each edge, plus directed scenario checks.
module tb_pwm_stage;
  import pwm_stage_pkg::*;

  localparam int EXP_W = 17;

  typedef struct packed {
    logic [1:0] st;
    logic       rdy;
    logic [3:0] act;
    logic       pwm;
    logic       pd;
    logic [7:0] per;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] count = '0;
  logic       enable = 1'b0;
  logic [3:0] duty_in = '0;
  logic       duty_valid = 1'b0;
  logic       duty_ready;
  logic [3:0] duty_active;
  logic       pwm_out;
  logic       period_done;
  pwm_state_e state_dbg;
`ifdef PWM_PERIOD_CNT_EN
  logic [7:0] periods;
`endif

  pwm_stage dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .enable      (enable),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .duty_active (duty_active),
    .pwm_out     (pwm_out),
    .period_done (period_done),
`ifdef PWM_PERIOD_CNT_EN
    .periods     (periods),
`endif
    .state_dbg   (state_dbg)
  );

  int n_checks = 0;
  int n_pass = 0;
  int hi_cnt = 0;
  int pd_cnt = 0;

  logic [EXP_W-1:0] exp_q[$];

  pwm_state_e m_state;
  logic [3:0] m_active, m_shadow;
  logic       m_pwm, m_pd;
  logic [7:0] m_periods;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // reference model: expected outputs after the coming edge
  task automatic model_step();
    logic rdy, xfer, bnd, n_pwm;
    exp_t e;
    if (!rst) begin
      m_state = IDLE; m_active = '0; m_shadow = '0;
      m_pwm = 1'b0; m_pd = 1'b0; m_periods = '0;
    end else begin
      rdy   = (m_state != PEND);
      xfer  = duty_valid && rdy;
      bnd   = (m_state != IDLE) && (count == 4'hF);
      n_pwm = (m_state != IDLE) && (count < m_active);
      if (m_pd && m_periods != 8'hFF) m_periods = m_periods + 8'd1;
      m_pd  = bnd;
      m_pwm = n_pwm;
      case (m_state)
        IDLE: begin
          if (xfer) m_active = duty_in;
          if (enable) m_state = RUN;
        end
        RUN: begin
          if (!enable) begin
            if (xfer) m_active = duty_in;
            m_state = IDLE;
          end else if (xfer) begin
            if (bnd) m_active = duty_in;
            else begin m_shadow = duty_in; m_state = PEND; end
          end
        end
        default: begin
          if (!enable) begin m_active = m_shadow; m_state = IDLE; end
          else if (bnd) begin m_active = m_shadow; m_state = RUN; end
        end
      endcase
    end
    e = '{st: m_state, rdy: (m_state != PEND), act: m_active, pwm: m_pwm, pd: m_pd, per: m_periods};
    exp_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("state", state_dbg, e.st);
    check("duty_ready", duty_ready, e.rdy);
    check("duty_active", duty_active, e.act);
    check("pwm_out", pwm_out, e.pwm);
    check("period_done", period_done, e.pd);
`ifdef PWM_PERIOD_CNT_EN
    check("periods", periods, e.per);
`endif
    if (pwm_out === 1'b1) hi_cnt++;
    if (period_done === 1'b1) pd_cnt++;
  endtask

  // driver: one clock cycle with the given inputs
  task automatic cyc(input logic [3:0] c, input logic en, input logic [3:0] d, input logic v);
    count = c; enable = en; duty_in = d; duty_valid = v;
    model_step();
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    logic [3:0] c;
    @(posedge clk);
    #1;

    // reset with traffic on the inputs
    rst = 1'b0;
    cyc(4'd7, 1'b0, 4'd9, 1'b1);
    cyc(4'd7, 1'b0, 4'd9, 1'b1);
    check("rst_active", duty_active, 32'd0);
    check("rst_pwm", pwm_out, 32'd0);
    check("rst_ready", duty_ready, 32'd1);
    check("rst_state", state_dbg, IDLE);
    rst = 1'b1;

    // steady PWM at duty 5
    cyc(4'd0, 1'b0, 4'd5, 1'b1);
    check("idle_load", duty_active, 32'd5);
    cyc(4'd0, 1'b1, 4'd0, 1'b0);
    check("enter_run", state_dbg, RUN);
    for (int p = 0; p < 3; p++) begin
      hi_cnt = 0; pd_cnt = 0;
      for (int i = 0; i < 16; i++) cyc(i[3:0], 1'b1, 4'd0, 1'b0);
      check("hi_per_period", hi_cnt, 32'd5);
      check("pd_per_period", pd_cnt, 32'd1);
    end

    // mid-period update deferred to the boundary
    for (int i = 0; i < 3; i++) cyc(i[3:0], 1'b1, 4'd0, 1'b0);
    cyc(4'd3, 1'b1, 4'd12, 1'b1);
    check("mid_ready", duty_ready, 32'd0);
    check("mid_hold", duty_active, 32'd5);
    for (int i = 4; i < 15; i++) cyc(i[3:0], 1'b1, 4'd0, 1'b1);
    check("mid_hold_end", duty_active, 32'd5);
    cyc(4'd15, 1'b1, 4'd0, 1'b0);
    check("mid_apply", duty_active, 32'd12);
    check("mid_run", state_dbg, RUN);

    // transfer on the boundary cycle
    for (int i = 0; i < 15; i++) cyc(i[3:0], 1'b1, 4'd0, 1'b0);
    cyc(4'd15, 1'b1, 4'd9, 1'b1);
    check("bnd_active", duty_active, 32'd9);
    check("bnd_state", state_dbg, RUN);
    check("bnd_ready", duty_ready, 32'd1);

    // enable drop while pending
    for (int i = 0; i < 5; i++) cyc(i[3:0], 1'b1, 4'd0, 1'b0);
    cyc(4'd5, 1'b1, 4'd10, 1'b1);
    check("pend_state", state_dbg, PEND);
    cyc(4'd6, 1'b0, 4'd0, 1'b0);
    check("drop_state", state_dbg, IDLE);
    check("drop_active", duty_active, 32'd10);
    cyc(4'd7, 1'b0, 4'd0, 1'b0);
    check("drop_pwm", pwm_out, 32'd0);

    // reset in the middle of PEND discards the shadow
    cyc(4'd0, 1'b1, 4'd0, 1'b0);
    cyc(4'd1, 1'b1, 4'd3, 1'b1);
    rst = 1'b0;
    cyc(4'd2, 1'b1, 4'd0, 1'b0);
    check("pend_rst_active", duty_active, 32'd0);
    rst = 1'b1;
    cyc(4'd3, 1'b0, 4'd0, 1'b0);
    check("pend_rst_active2", duty_active, 32'd0);

    // random traffic with shortened periods and occasional resets
    c = 4'd0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) c = 4'($urandom_range(0, 15));
      else c = c + 4'd1;
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      cyc(c, enable, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end
    rst = 1'b1;

`ifdef PWM_PERIOD_CNT_EN
    rst = 1'b0;
    cyc(4'd0, 1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 302; i++) cyc(4'd15, 1'b1, 4'd0, 1'b0);
    check("sat_periods", periods, 32'd255);
    for (int i = 0; i < 10; i++) cyc(4'd15, 1'b1, 4'd0, 1'b0);
    check("sat_hold", periods, 32'd255);
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
